// File: rtl/scan_select_gen.sv
// Double-buffered two-digit scan driver: A/B shadows, periodic selection toggle, active-low enables.
// Latency: loads reach a_q/b_q on the first toggle edge after the load (1..DIV cycles, plus frozen cycles).
// Backpressure: none; freeze holds the scan while loads keep landing in the shadows.
module scan_select_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV       = 50000,
    parameter int BLANK     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] din,
    input  logic       load_a,
    input  logic       load_b,
    input  logic       freeze,
    output logic [3:0] a_q,
    output logic [3:0] b_q,
    output logic       selection,
    output logic [1:0] an,
    output logic       tick,
    output logic [1:0] pending
);

    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV - 1);

    logic [DIV_WIDTH-1:0] cnt;
    logic [3:0]           sh_a;
    logic [3:0]           sh_b;
    logic                 pend_a;
    logic                 pend_b;
    logic                 toggle;
    logic                 in_blank;

    assign toggle  = (cnt == CNT_LAST) && !freeze;
    assign pending = {pend_b, pend_a};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            selection <= 1'b1;
            tick      <= 1'b0;
        end else if (freeze) begin
            tick <= 1'b0;
        end else if (toggle) begin
            cnt       <= '0;
            selection <= ~selection;
            tick      <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_WIDTH'(1);
            tick <= 1'b0;
        end
    end

    // A load on the toggle edge wins over the pending clear: the new value waits for the next slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_a   <= 4'h0;
            sh_b   <= 4'h0;
            a_q    <= 4'h0;
            b_q    <= 4'h0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            if (toggle && pend_a) a_q <= sh_a;
            if (toggle && pend_b) b_q <= sh_b;

            if (load_a) begin
                sh_a   <= din;
                pend_a <= 1'b1;
            end else if (toggle) begin
                pend_a <= 1'b0;
            end

            if (load_b) begin
                sh_b   <= din;
                pend_b <= 1'b1;
            end else if (toggle) begin
                pend_b <= 1'b0;
            end
        end
    end

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [DIV_WIDTH:0] BLANK_V = (DIV_WIDTH + 1)'(BLANK);
            assign in_blank = ({1'b0, cnt} < BLANK_V);
        end
    endgenerate

    always_comb begin
        an = 2'b11;
        if (!in_blank) an = selection ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_scan_select_gen.sv
// Directed bench for scan_select_gen with DIV=8, BLANK=2; expected values are hand-computed per edge.
module tb_scan_select_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] din;
    logic       load_a;
    logic       load_b;
    logic       freeze;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       selection;
    logic [1:0] an;
    logic       tick;
    logic [1:0] pending;

    int tests = 0;
    int fails = 0;
    int ticks_seen;

    scan_select_gen #(.DIV_WIDTH(16), .DIV(8), .BLANK(2)) dut (
        .clk(clk), .resetn(resetn), .din(din), .load_a(load_a), .load_b(load_b),
        .freeze(freeze), .a_q(a_q), .b_q(b_q), .selection(selection), .an(an),
        .tick(tick), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs and checks happen 1 time unit after the edge.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_q"}, 8'(a_q), 8'h0);
        chk({tag, "_b_q"}, 8'(b_q), 8'h0);
        chk({tag, "_sel"}, 8'(selection), 8'h1);
        chk({tag, "_an"}, 8'(an), 8'h3);
        chk({tag, "_pend"}, 8'(pending), 8'h0);
        chk({tag, "_tick"}, 8'(tick), 8'h0);
    endtask

    initial begin
        resetn = 1'b0; din = 4'h0; load_a = 1'b0; load_b = 1'b0; freeze = 1'b0;
        // Reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            din = 4'($urandom); load_a = 1'($urandom); load_b = 1'($urandom);
            freeze = 1'($urandom);
        end
        chk_reset_state("rst");
        din = 4'h0; load_a = 1'b0; load_b = 1'b0; freeze = 1'b0;
        resetn = 1'b1;

        // Edge numbers below count rising edges since reset release
        adv(1);  chk("e1_an_blank", 8'(an), 8'h3);
        chk("e1_tick", 8'(tick), 8'h0);
        adv(1);  chk("e2_an_a", 8'(an), 8'h2);
        adv(5);  chk("e7_no_tick", 8'(tick), 8'h0);
        chk("e7_sel", 8'(selection), 8'h1);
        adv(1);  chk("e8_tick", 8'(tick), 8'h1);
        chk("e8_sel", 8'(selection), 8'h0);
        chk("e8_an_blank", 8'(an), 8'h3);
        adv(1);  chk("e9_tick_low", 8'(tick), 8'h0);
        chk("e9_an_blank", 8'(an), 8'h3);
        adv(1);  chk("e10_an_b", 8'(an), 8'h1);
        ticks_seen = 0;
        for (int i = 0; i < 6; i++) begin
            adv(1);
            ticks_seen += int'(tick);
        end
        chk("e16_tick", 8'(tick), 8'h1);
        chk("e11_16_ticks", 8'(ticks_seen), 8'h1);
        chk("e16_sel", 8'(selection), 8'h1);

        // Double buffering: load A=5 at cnt=3
        adv(3);  din = 4'h5; load_a = 1'b1;
        adv(1);  load_a = 1'b0;
        chk("e20_a_hold", 8'(a_q), 8'h0);
        chk("e20_pend", 8'(pending), 8'h1);
        adv(3);  chk("e23_a_hold", 8'(a_q), 8'h0);
        adv(1);  chk("e24_a_shown", 8'(a_q), 8'h5);
        chk("e24_pend_clr", 8'(pending), 8'h0);

        // Overwrite before toggle: 9 then C
        adv(1);  din = 4'h9; load_a = 1'b1;
        adv(1);  load_a = 1'b0;
        adv(1);  din = 4'hC; load_a = 1'b1;
        adv(1);  load_a = 1'b0;
        adv(3);  chk("e31_a_hold", 8'(a_q), 8'h5);
        adv(1);  chk("e32_a_last", 8'(a_q), 8'hC);

        // Load on the toggle edge with pend_a clear
        adv(7);  din = 4'h7; load_a = 1'b1;
        adv(1);  load_a = 1'b0;
        chk("e40_a_unch", 8'(a_q), 8'hC);
        chk("e40_pend", 8'(pending), 8'h1);
        chk("e40_tick", 8'(tick), 8'h1);
        adv(8);  chk("e48_a_seven", 8'(a_q), 8'h7);
        chk("e48_pend_clr", 8'(pending), 8'h0);

        // Simultaneous A+B load
        adv(2);  din = 4'h3; load_a = 1'b1; load_b = 1'b1;
        adv(1);  load_a = 1'b0; load_b = 1'b0;
        chk("e51_pend_both", 8'(pending), 8'h3);
        adv(5);  chk("e56_a_three", 8'(a_q), 8'h3);
        chk("e56_b_three", 8'(b_q), 8'h3);
        chk("e56_sel", 8'(selection), 8'h0);

        // Freeze at cnt=5 for 20 edges, with a B load inside
        adv(5);  freeze = 1'b1;
        ticks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            ticks_seen += int'(tick);
            if (i == 3) begin din = 4'hE; load_b = 1'b1; end
            if (i == 4) load_b = 1'b0;
        end
        chk("frz_ticks", 8'(ticks_seen), 8'h0);
        chk("frz_sel", 8'(selection), 8'h0);
        chk("frz_an", 8'(an), 8'h1);
        chk("frz_pend", 8'(pending), 8'h2);
        chk("frz_b_hold", 8'(b_q), 8'h3);
        freeze = 1'b0;
        adv(2);  chk("unfrz2_tick", 8'(tick), 8'h0);
        adv(1);  chk("unfrz3_tick", 8'(tick), 8'h1);
        chk("unfrz3_b", 8'(b_q), 8'hE);
        chk("unfrz3_sel", 8'(selection), 8'h1);

        // Freeze inside the blank window keeps enables off
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            adv(1);
            chk("frzblank_an", 8'(an), 8'h3);
        end
        freeze = 1'b0;
        adv(1);  chk("blank_cnt1_an", 8'(an), 8'h3);
        adv(1);  chk("blank_cnt2_an", 8'(an), 8'h2);

        // Reset mid-slot with both loads pending at cnt=4
        din = 4'h9; load_a = 1'b1; load_b = 1'b1;
        adv(1);  load_a = 1'b0; load_b = 1'b0;
        chk("prerst_pend", 8'(pending), 8'h3);
        adv(1);
        resetn = 1'b0;
        #1;
        chk_reset_state("midrst");
        resetn = 1'b1;
        adv(7);  chk("rel_e7_tick", 8'(tick), 8'h0);
        adv(1);  chk("rel_e8_tick", 8'(tick), 8'h1);
        chk("rel_e8_a", 8'(a_q), 8'h0);
        chk("rel_e8_b", 8'(b_q), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
